// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the fetch-stage sequencer: the sequencer state
//   enum, address geometry, the watchdog limit and the predicate that
//   decides whether a redirect target is a legal fetch address.
package pipe_pkg;

  localparam int AW          = 8;   // address width (signed at the PC)
  localparam int STEP        = 4;   // sequential word-fetch increment
  localparam int STALL_LIMIT = 16;  // consecutive stalls before FAULT
  localparam int STALL_CW    = $clog2(STALL_LIMIT);

  // A legal target has the sign bit clear and is word aligned.
  localparam int SIGN_BIT   = AW - 1;
  localparam int ALIGN_BITS = 2;
  localparam logic [AW-1:0] ILLEGAL_MASK =
    AW'((1 << SIGN_BIT) | ((1 << ALIGN_BITS) - 1));

  // Sequential fetch wraps inside the positive half of the address space.
  localparam logic [AW-1:0] WRAP_MASK = AW'((1 << SIGN_BIT) - 1);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    STALL,
    HALT,
    FAULT
  } seq_state_e;

  function automatic logic addr_legal(input logic [AW-1:0] addr);
    return (addr & ILLEGAL_MASK) == '0;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the sequencer's hazard/branch inputs and its PC-side outputs.
//   master : the surrounding pipeline (drives requests, observes results)
//   slave  : the pc_sequencer itself
interface pc_sequencer_if;
  import pipe_pkg::*;

  logic [AW-1:0] curr_addr;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          jmp;
  logic [AW-1:0] jmp_target;
  logic          halt_req;
  logic [AW-1:0] next_addr;
  logic          fetch_valid;
  logic          flush_if;
  logic          flush_id;
  logic          halted;
  logic          fault;
  logic [7:0]    fetch_count;

  modport master (
    output curr_addr, stall, br_taken, br_target, jmp, jmp_target, halt_req,
    input  next_addr, fetch_valid, flush_if, flush_id, halted, fault, fetch_count
  );

  modport slave (
    input  curr_addr, stall, br_taken, br_target, jmp, jmp_target, halt_req,
    output next_addr, fetch_valid, flush_if, flush_id, halted, fault, fetch_count
  );

endinterface

// File: rtl/target_check.sv
// target_check
//   Combinational legality check for a redirect target.
//   target : candidate fetch address
//   legal  : 1 when the target is word aligned and non-negative
module target_check
  import pipe_pkg::*;
(
  input  logic [AW-1:0] target,
  output logic          legal
);

  assign legal = addr_legal(target);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage controller. Every cycle it chooses the address the PC
//   register loads on the next edge, arbitrating branch > jump > halt >
//   stall > sequential, and raises IF/ID flush strobes on redirects.
//   Illegal targets or a stall lasting STALL_LIMIT cycles trap into FAULT.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : curr_addr/stall/br_*/jmp*/halt_req in;
//                next_addr/flush_*/fetch_valid/halted/fault/fetch_count out
module pc_sequencer
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  seq_state_e          state, next_state;
  logic [STALL_CW-1:0] stall_cnt;
  logic [7:0]          fetch_count;
  logic                fetch_valid, halted, fault;

  logic [AW-1:0] next_addr;
  logic          flush_if, flush_id;
  logic          stall_sel;
  logic          br_legal, jmp_legal;
  logic [AW-1:0] seq_addr;

  target_check u_br_check  (.target(bus.br_target),  .legal(br_legal));
  target_check u_jmp_check (.target(bus.jmp_target), .legal(jmp_legal));

  assign seq_addr = (bus.curr_addr + AW'(STEP)) & WRAP_MASK;

  // Selection mux. A taken branch squashes the younger jump/halt/stall
  // requests; an illegal target freezes the PC and flushes both stages.
  always_comb begin
    next_addr  = '0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    stall_sel  = 1'b0;
    next_state = state;
    unique case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN, STALL: begin
        if (bus.br_taken) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          if (br_legal) begin
            next_addr  = bus.br_target;
            next_state = RUN;
          end else begin
            next_addr  = bus.curr_addr;
            next_state = FAULT;
          end
        end else if (bus.jmp) begin
          flush_if = 1'b1;
          if (jmp_legal) begin
            next_addr  = bus.jmp_target;
            next_state = RUN;
          end else begin
            flush_id   = 1'b1;
            next_addr  = bus.curr_addr;
            next_state = FAULT;
          end
        end else if (bus.halt_req) begin
          next_addr  = bus.curr_addr;
          next_state = HALT;
        end else if (bus.stall) begin
          stall_sel  = 1'b1;
          next_addr  = bus.curr_addr;
          // Watchdog: the STALL_LIMIT-th consecutive stall traps.
          next_state = (stall_cnt == STALL_CW'(STALL_LIMIT - 1)) ? FAULT : STALL;
        end else begin
          next_addr  = seq_addr;
          next_state = RUN;
        end
      end
      HALT, FAULT: begin
        next_addr = bus.curr_addr;
      end
      default: begin
        next_state = FAULT;
      end
    endcase
  end

  // State, counters and the state-decoded status flags, all updated on the
  // same edge the PC loads next_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      stall_cnt   <= '0;
      fetch_count <= '0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= next_state;
      fetch_valid <= (next_state == RUN) || (next_state == STALL);
      halted      <= (next_state == HALT);
      fault       <= (next_state == FAULT);
      if (state == RUN || state == STALL) begin
        stall_cnt <= stall_sel ? stall_cnt + 1'b1 : '0;
        if (!stall_sel && fetch_count != 8'hFF) begin
          fetch_count <= fetch_count + 8'd1;
        end
      end
    end
  end

  assign bus.next_addr   = next_addr;
  assign bus.flush_if    = flush_if;
  assign bus.flush_id    = flush_id;
  assign bus.fetch_valid = fetch_valid;
  assign bus.halted      = halted;
  assign bus.fault       = fault;
  assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed-vector scoreboard bench for pc_sequencer. Each vector drives the
//   inputs for one cycle and queues the hand-computed outputs for that cycle;
//   a monitor on the falling edge pops and compares them.
module tb_pc_sequencer;
  import pipe_pkg::*;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] next_addr;
    logic       fetch_valid;
    logic       flush_if;
    logic       flush_id;
    logic       halted;
    logic       fault;
    logic [7:0] fetch_count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic checkOutput(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e.name, "next_addr",   bus.next_addr,           mon_e.next_addr);
      checkOutput(mon_e.name, "fetch_valid", {7'b0, bus.fetch_valid}, {7'b0, mon_e.fetch_valid});
      checkOutput(mon_e.name, "flush_if",    {7'b0, bus.flush_if},    {7'b0, mon_e.flush_if});
      checkOutput(mon_e.name, "flush_id",    {7'b0, bus.flush_id},    {7'b0, mon_e.flush_id});
      checkOutput(mon_e.name, "halted",      {7'b0, bus.halted},      {7'b0, mon_e.halted});
      checkOutput(mon_e.name, "fault",       {7'b0, bus.fault},       {7'b0, mon_e.fault});
      checkOutput(mon_e.name, "fetch_count", bus.fetch_count,         mon_e.fetch_count);
    end
  end

  // One cycle of stimulus: inputs applied just after the rising edge,
  // expected outputs for that same cycle queued for the monitor.
  task automatic applyStimulus(
    input string name, input logic rst, input logic [7:0] curr,
    input logic stall, input logic br, input logic [7:0] brt,
    input logic jmp, input logic [7:0] jt, input logic halt,
    input logic [7:0] na, input logic fv, input logic fi, input logic fd,
    input logic hl, input logic ft, input logic [7:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    bus.curr_addr  = curr;
    bus.stall      = stall;
    bus.br_taken   = br;
    bus.br_target  = brt;
    bus.jmp        = jmp;
    bus.jmp_target = jt;
    bus.halt_req   = halt;
    e.name        = name;
    e.next_addr   = na;
    e.fetch_valid = fv;
    e.flush_if    = fi;
    e.flush_id    = fd;
    e.halted      = hl;
    e.fault       = ft;
    e.fetch_count = fc;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.curr_addr  = '0;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.jmp        = 1'b0;
    bus.jmp_target = '0;
    bus.halt_req   = 1'b0;

    //             name            rst curr  st br brt  jm jt     hl   na fv fi fd hl ft fc
    applyStimulus("reset",         0,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot",          1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("seq0",          1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 0);
    applyStimulus("seq1",          1,  4,    0, 0, 0,   0, 0,     0,   8, 1, 0, 0, 0, 0, 1);
    applyStimulus("seq2",          1,  8,    0, 0, 0,   0, 0,     0,  12, 1, 0, 0, 0, 0, 2);
    applyStimulus("seq3",          1,  12,   0, 0, 0,   0, 0,     0,  16, 1, 0, 0, 0, 0, 3);
    applyStimulus("wrap",          1,  124,  0, 0, 0,   0, 0,     0,   0, 1, 0, 0, 0, 0, 4);
    applyStimulus("after_wrap",    1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 5);
    applyStimulus("branch_prio",   1,  16,   1, 1, 40,  1, 80,    0,  40, 1, 1, 1, 0, 0, 6);
    applyStimulus("jump",          1,  40,   0, 0, 0,   1, 80,    0,  80, 1, 1, 0, 0, 0, 7);
    applyStimulus("jump_over_halt",1,  80,   0, 0, 0,   1, 100,   1, 100, 1, 1, 0, 0, 0, 8);

    for (int i = 0; i < 15; i++)
      applyStimulus($sformatf("stall15_%0d", i), 1, 20, 1, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 9);
    applyStimulus("stall15_resume",1,  20,   0, 0, 0,   0, 0,     0,  24, 1, 0, 0, 0, 0, 9);

    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("stall16_%0d", i), 1, 20, 1, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 10);
    applyStimulus("watchdog_fault",1,  20,   0, 1, 40,  0, 0,     0,  20, 0, 0, 0, 0, 1, 10);

    applyStimulus("reset2",        0,  20,   0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot2",         1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("run2",          1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 0);
    applyStimulus("jmp_misalign",  1,  4,    0, 0, 0,   1, 8'h42, 0,   4, 1, 1, 1, 0, 0, 1);
    applyStimulus("misalign_fault",1,  4,    0, 0, 0,   0, 0,     0,   4, 0, 0, 0, 0, 1, 2);
    applyStimulus("fault_frozen",  1,  4,    0, 1, 8,   0, 0,     0,   4, 0, 0, 0, 0, 1, 2);

    applyStimulus("reset3",        0,  4,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot3",         1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("run3",          1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 0);
    applyStimulus("jmp_negative",  1,  4,    0, 0, 0,   1, 8'h90, 0,   4, 1, 1, 1, 0, 0, 1);
    applyStimulus("negative_fault",1,  4,    0, 0, 0,   0, 0,     0,   4, 0, 0, 0, 0, 1, 2);

    applyStimulus("reset4",        0,  4,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot4",         1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("run4",          1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 0);
    applyStimulus("br_misalign",   1,  4,    0, 1, 8'h0A,0, 0,    0,   4, 1, 1, 1, 0, 0, 1);
    applyStimulus("br_fault",      1,  4,    0, 0, 0,   0, 0,     0,   4, 0, 0, 0, 0, 1, 2);

    applyStimulus("reset5",        0,  4,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot5",         1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("run5",          1,  0,    0, 0, 0,   0, 0,     0,   4, 1, 0, 0, 0, 0, 0);
    applyStimulus("halt_req",      1,  4,    1, 0, 0,   0, 0,     1,   4, 1, 0, 0, 0, 0, 1);
    applyStimulus("halted",        1,  4,    0, 0, 0,   1, 8,     0,   4, 0, 0, 0, 1, 0, 2);
    applyStimulus("halted_stall",  1,  4,    1, 0, 0,   0, 0,     0,   4, 0, 0, 0, 1, 0, 2);
    applyStimulus("reset_in_halt", 0,  4,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus("boot6",         1,  0,    0, 0, 0,   0, 0,     0,   0, 0, 0, 0, 0, 0, 0);

    // Fetch counter saturation: the count seen in cycle i is min(i, 255).
    for (int i = 0; i < 260; i++)
      applyStimulus($sformatf("sat_%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,
                    (i > 255) ? 8'd255 : 8'(i));

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
